// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
//   Takes a byte stream framed as {len_hi, len_lo, N big-endian 32-bit words,
//   checksum}. Each assembled word goes out on the memory write port. The CPU
//   is held in clear until a load finishes with a good checksum.
// Ports:
//   clk, clr_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse; begins a load from IDLE/DONE/ERROR
//   rx_valid/rx_data    byte stream in; a transfer needs rx_valid & rx_ready
//   rx_ready            loader accepts a byte this cycle
//   im_we/im_addr/im_din  word write port (im_we 4'b1111 for one cycle)
//   cpu_clr             CPU clear, low only after a good load
//   busy/done/err       status; err_code 01 len overflow, 10 cksum, 11 timeout
//   word_cnt            words written in the current load
// Optional: define IMEM_LOADER_TIMEOUT_EN to abort after TIMEOUT_CYC cycles
// with no accepted byte.
module imem_loader #(
    parameter int ADDR_W      = 13,
    parameter int MAX_WORDS   = 8192,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [3:0]        im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_din,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_cnt
);

    // Parameter sanity: address wrap is ruled out only if the word limit fits.
    if (MAX_WORDS > (1 << ADDR_W) || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("imem_loader: illegal parameters");
    end

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CKSUM, DONE, ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       wbuf_q, wbuf_d;      // first three bytes of the word
    logic [7:0]        sum_q, sum_d;
    logic [3:0]        im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_din_q, im_din_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              rx_ready_q, rx_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_clr_q, cpu_clr_d;

    logic              accept;
    logic [7:0]        sum_nxt;
    logic [15:0]       len_nxt;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bidx_d     = bidx_q;
        wbuf_d     = wbuf_q;
        sum_d      = sum_q;
        im_we_d    = 4'b0000;
        im_addr_d  = im_addr_q;
        im_din_d   = im_din_q;
        word_cnt_d = word_cnt_q;
        err_code_d = err_code_q;
`ifdef IMEM_LOADER_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        // rx_ready_q is high exactly in the receiving states
        accept  = rx_valid & rx_ready_q;
        sum_nxt = sum_q + rx_data;
        len_nxt = {len_q[15:8], rx_data};

        case (state_q)
            LEN_HI: if (accept) begin
                len_d[15:8] = rx_data;
                sum_d       = sum_nxt;
                state_d     = LEN_LO;
            end
            LEN_LO: if (accept) begin
                len_d = len_nxt;
                sum_d = sum_nxt;
                if (32'(len_nxt) > MAX_WORDS) begin
                    state_d    = ERROR;
                    err_code_d = 2'b01;
                end else if (len_nxt == 16'd0) begin
                    state_d = CKSUM;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (accept) begin
                sum_d  = sum_nxt;
                bidx_d = bidx_q + 2'd1;
                if (bidx_q == 2'd3) begin
                    im_we_d    = 4'b1111;
                    im_addr_d  = word_cnt_q[ADDR_W-1:0];
                    im_din_d   = {wbuf_q, rx_data};
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (32'(word_cnt_q) + 32'd1 == 32'(len_q))
                        state_d = CKSUM;
                end else begin
                    wbuf_d = {wbuf_q[15:0], rx_data};
                end
            end
            CKSUM: if (accept) begin
                sum_d = sum_nxt;
                if (sum_nxt == 8'h00) begin
                    state_d = DONE;
                end else begin
                    state_d    = ERROR;
                    err_code_d = 2'b10;
                end
            end
            default: ;   // IDLE, DONE, ERROR: only start matters
        endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
        if (rx_ready_q) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_d    = ERROR;
                err_code_d = 2'b11;
                tmo_d      = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif

        // start is honoured only when no load is in flight
        if (start && (state_q == IDLE || state_q == DONE || state_q == ERROR)) begin
            state_d    = LEN_HI;
            len_d      = '0;
            bidx_d     = '0;
            sum_d      = '0;
            word_cnt_d = '0;
            err_code_d = 2'b00;
`ifdef IMEM_LOADER_TIMEOUT_EN
            tmo_d      = '0;
`endif
        end

        // Status flags are registered from the next state.
        rx_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                     (state_d == DATA)   || (state_d == CKSUM);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERROR);
        cpu_clr_d  = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            bidx_q     <= '0;
            wbuf_q     <= '0;
            sum_q      <= '0;
            im_we_q    <= '0;
            im_addr_q  <= '0;
            im_din_q   <= '0;
            word_cnt_q <= '0;
            err_code_q <= '0;
            rx_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_clr_q  <= 1'b1;
`ifdef IMEM_LOADER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            bidx_q     <= bidx_d;
            wbuf_q     <= wbuf_d;
            sum_q      <= sum_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_din_q   <= im_din_d;
            word_cnt_q <= word_cnt_d;
            err_code_q <= err_code_d;
            rx_ready_q <= rx_ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_clr_q  <= cpu_clr_d;
`ifdef IMEM_LOADER_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign rx_ready = rx_ready_q;
    assign busy     = rx_ready_q;   // busy and rx_ready share the same states
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_din   = im_din_q;
    assign cpu_clr  = cpu_clr_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction ROM/RAM. The fetch unit only ever reads this memory with its write-enable tied off; this block drives the write port.
- Accepts a byte stream (typically from a UART receiver) framed as length header, big-endian instruction words, then checksum. Writes each assembled word into instruction memory.
- Holds the CPU in clear until a load completes with a valid checksum.

Parameters:
- ADDR_W, 13, word-address width of the instruction memory port (8K words).
- MAX_WORDS, 8192, largest accepted word count. Must be <= 2^ADDR_W.
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles. Used only with IMEM_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid & rx_ready
- im_we  out  4  memory byte write enables, 4'b1111 for a word write, else 4'b0000
- im_addr  out  ADDR_W  word address
- im_din  out  32  write data
- cpu_clr  out  1  active-high clear to the CPU/fetch unit
- busy  out  1  load in progress
- done  out  1  load finished with checksum OK
- err  out  1  load aborted
- err_code  out  2  01 length overflow, 10 checksum mismatch, 11 timeout, 00 none
- word_cnt  out  ADDR_W+1  words written in the current load

Behaviour:
- Reset (clr_n low, async):
  - State goes to IDLE.
  - im_we=0, im_addr=0, im_din=0, rx_ready=0, busy=0, done=0, err=0, err_code=00, word_cnt=0, cpu_clr=1.
  - Takes effect immediately, including mid-load. A pending im_we is dropped.
- All outputs are registered.
- States: IDLE, LEN_HI, LEN_LO, DATA, CKSUM, DONE, ERROR.
- IDLE: start moves to LEN_HI. In every other state except DONE and ERROR, start is ignored.
- DONE / ERROR: start restarts the load. Next cycle is LEN_HI with done=0, err=0, err_code=00, word_cnt=0, cpu_clr=1.
- rx_ready=1 exactly in LEN_HI, LEN_LO, DATA and CKSUM. busy=1 in the same states.
- Word count N is 16-bit big-endian: LEN_HI byte first, then LEN_LO.
  - On LEN_LO accept with N > MAX_WORDS: go to ERROR, err_code=01.
  - On LEN_LO accept with N == 0: go to CKSUM.
  - Otherwise go to DATA.
- DATA assembly:
  - Byte index 0..3; word = {b0,b1,b2,b3}.
  - On the 4th accepted byte: the next cycle has im_we=4'b1111, im_addr = current word index, im_din = word, for exactly one cycle. word_cnt increments in that same cycle.
  - Assembly continues without stall: rx_ready stays 1 during the write cycle.
  - After word N-1 is accepted, go to CKSUM.
- Checksum: sum mod 256 of both length bytes, all data bytes and the checksum byte.
  - Sum == 0x00: go to DONE with done=1, cpu_clr=0.
  - Otherwise: go to ERROR with err=1, err_code=10, cpu_clr stays 1.
- cpu_clr is 0 only in DONE.
- Address wrap cannot occur, because N <= MAX_WORDS <= 2^ADDR_W.

Optional Feature:
- IMEM_LOADER_TIMEOUT_EN defined:
  - An idle counter runs in LEN_HI..CKSUM. It clears on every accepted byte and on entry to LEN_HI.
  - After TIMEOUT_CYC consecutive cycles with no accepted byte: go to ERROR, err_code=11.
- Not defined:
  - No counter is built and the loader waits indefinitely.
  - err_code=11 is never produced.

Test Plan:
- Reset, no start -> cpu_clr=1, rx_ready=0, im_we=0, busy=0, done=0, err_code=00.
- Start, then bytes 00 02 24 08 00 05 00 00 00 00 CD:
  - Writes addr 0 = 0x24080005, then addr 1 = 0x00000000; each im_we=4'b1111 for one cycle, one cycle after the 4th byte.
  - Ends with done=1, cpu_clr=0, word_cnt=2.
- Same stream with last byte CE -> ERROR, err_code=10, cpu_clr=1, done=0. A following start plus the correct stream then succeeds.
- Bytes 20 01 (N=8193) -> ERROR after the second byte, err_code=01, no im_we pulse. Bytes 00 00 00 -> done=1, word_cnt=0, no writes.
- clr_n pulsed low after 2 data bytes -> immediate IDLE, cpu_clr=1, rx_ready=0. Restart loads the full image correctly from word 0.
- TIMEOUT_CYC=16 with macro, stall after the first length byte -> ERROR, err_code=11 after 16 idle cycles. Without the macro -> still in LEN_LO with busy=1 after 1000 cycles.
